// File: rtl/relu_pool1_pkg.sv
// rtl/relu_pool1_pkg.sv - shared layer-1 network parameters for conv/relu/pool stages
package relu_pool1_pkg;

  localparam int L1_IMG_WIDTH = 24;
  localparam int L1_IN_WIDTH  = 32;
  localparam int L1_OUT_WIDTH = 8;
  localparam int L1_SHIFT     = 8;
  localparam int N_CH         = 6;

  // Column/row counters need at least two bits so col>>1 stays a legal slice.
  function automatic int cnt_width(input int n);
    return (n < 4) ? 2 : $clog2(n);
  endfunction

endpackage

// File: rtl/relu_requant.sv
// rtl/relu_requant.sv - per-channel ReLU, arithmetic shift and saturation to the positive range
module relu_requant
  import relu_pool1_pkg::*;
#(
  parameter int IN_WIDTH  = L1_IN_WIDTH,
  parameter int OUT_WIDTH = L1_OUT_WIDTH,
  parameter int SHIFT     = L1_SHIFT
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout
);

  localparam logic signed [IN_WIDTH-1:0] QMAX = IN_WIDTH'(2 ** (OUT_WIDTH - 1) - 1);

  logic signed [IN_WIDTH-1:0] shifted;

  always_comb begin
    shifted = din >>> SHIFT;
    if (din[IN_WIDTH-1]) begin
      dout = '0;
    end else if (shifted > QMAX) begin
      dout = QMAX[OUT_WIDTH-1:0];
    end else begin
      dout = shifted[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/relu_pool1.sv
// rtl/relu_pool1.sv - six-channel ReLU/requantize followed by streaming 2x2 max pooling
module relu_pool1
  import relu_pool1_pkg::*;
#(
  parameter int IMG_WIDTH = L1_IMG_WIDTH,
  parameter int IN_WIDTH  = L1_IN_WIDTH,
  parameter int OUT_WIDTH = L1_OUT_WIDTH,
  parameter int SHIFT     = L1_SHIFT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_in,
  input  logic signed [IN_WIDTH-1:0]  in_ch0,
  input  logic signed [IN_WIDTH-1:0]  in_ch1,
  input  logic signed [IN_WIDTH-1:0]  in_ch2,
  input  logic signed [IN_WIDTH-1:0]  in_ch3,
  input  logic signed [IN_WIDTH-1:0]  in_ch4,
  input  logic signed [IN_WIDTH-1:0]  in_ch5,
  output logic signed [OUT_WIDTH-1:0] out_ch0,
  output logic signed [OUT_WIDTH-1:0] out_ch1,
  output logic signed [OUT_WIDTH-1:0] out_ch2,
  output logic signed [OUT_WIDTH-1:0] out_ch3,
  output logic signed [OUT_WIDTH-1:0] out_ch4,
  output logic signed [OUT_WIDTH-1:0] out_ch5,
  output logic                        valid_out,
  output logic                        frame_done
);

  localparam int CW = cnt_width(IMG_WIDTH);
  localparam int HW = IMG_WIDTH / 2;
  localparam logic [CW-1:0] LAST = CW'(IMG_WIDTH - 1);

  typedef logic signed [OUT_WIDTH-1:0] act_t;

  logic signed [IN_WIDTH-1:0] in_arr [N_CH];
  act_t q     [N_CH];
  act_t hreg  [N_CH];
  act_t out_r [N_CH];
  act_t lb    [HW][N_CH];

  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic [CW-2:0] lb_idx;
  logic          last_col;
  logic          last_row;

  function automatic act_t amax(input act_t a, input act_t b);
    return (a > b) ? a : b;
  endfunction

  assign in_arr[0] = in_ch0;
  assign in_arr[1] = in_ch1;
  assign in_arr[2] = in_ch2;
  assign in_arr[3] = in_ch3;
  assign in_arr[4] = in_ch4;
  assign in_arr[5] = in_ch5;

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_rq
      relu_requant #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .SHIFT    (SHIFT)
      ) u_rq (
        .din (in_arr[g]),
        .dout(q[g])
      );
    end
  endgenerate

  assign lb_idx   = col[CW-1:1];
  assign last_col = (col == LAST);
  assign last_row = (row == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      for (int ch = 0; ch < N_CH; ch++) begin
        hreg[ch]  <= '0;
        out_r[ch] <= '0;
      end
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (!col[0]) begin
          for (int ch = 0; ch < N_CH; ch++) hreg[ch] <= q[ch];
        end else if (row[0]) begin
          // Bottom-right pixel of a 2x2 window completes the pooled output.
          for (int ch = 0; ch < N_CH; ch++)
            out_r[ch] <= amax(amax(hreg[ch], q[ch]), lb[lb_idx][ch]);
          valid_out  <= 1'b1;
          frame_done <= last_col && last_row;
        end
      end
    end
  end

  // Line buffer carries the top-row pair maximum; it is deliberately not reset.
  always_ff @(posedge clk) begin
    if (valid_in && col[0] && !row[0]) begin
      for (int ch = 0; ch < N_CH; ch++) lb[lb_idx][ch] <= amax(hreg[ch], q[ch]);
    end
  end

  assign out_ch0 = out_r[0];
  assign out_ch1 = out_r[1];
  assign out_ch2 = out_r[2];
  assign out_ch3 = out_r[3];
  assign out_ch4 = out_r[4];
  assign out_ch5 = out_r[5];

endmodule

// File: tb/tb_relu_pool1.sv
// tb/tb_relu_pool1.sv - randomized self-checking bench for relu_pool1 against a frame-level model
module tb_relu_pool1;
  import relu_pool1_pkg::*;

  localparam int W    = 24;
  localparam int IW   = 32;
  localparam int OW   = 8;
  localparam int SH   = 8;
  localparam int QMAX = (1 << (OW - 1)) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic valid_in;
  logic signed [IW-1:0] in_ch [6];
  logic signed [OW-1:0] out_ch0, out_ch1, out_ch2, out_ch3, out_ch4, out_ch5;
  logic valid_out;
  logic frame_done;
  logic [47:0] dut_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int     cyc;
    longint data;
    bit     last;
  } exp_t;

  exp_t   exp_q[$];
  int     fq[6][W][W];
  int     r = 0;
  int     c = 0;
  int     out_cnt = 0;
  int     fd_cnt = 0;
  longint last_out = 0;

  relu_pool1 #(
    .IMG_WIDTH(W),
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW),
    .SHIFT    (SH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .in_ch0    (in_ch[0]),
    .in_ch1    (in_ch[1]),
    .in_ch2    (in_ch[2]),
    .in_ch3    (in_ch[3]),
    .in_ch4    (in_ch[4]),
    .in_ch5    (in_ch[5]),
    .out_ch0   (out_ch0),
    .out_ch1   (out_ch1),
    .out_ch2   (out_ch2),
    .out_ch3   (out_ch3),
    .out_ch4   (out_ch4),
    .out_ch5   (out_ch5),
    .valid_out (valid_out),
    .frame_done(frame_done)
  );

  assign dut_out = {out_ch5, out_ch4, out_ch3, out_ch2, out_ch1, out_ch0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Requantization rule stated directly: clamp negatives, divide by 2^SHIFT, cap at QMAX.
  function automatic int quant(input int x);
    int d;
    if (x <= 0) return 0;
    d = x / (1 << SH);
    return (d > QMAX) ? QMAX : d;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    bit   ev;
    if (!rst_n) begin
      check("rst_valid_out", {63'b0, valid_out}, 64'd0);
      check("rst_frame_done", {63'b0, frame_done}, 64'd0);
      check("rst_out", {16'b0, dut_out}, 64'd0);
      last_out = 0;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("out_missing_at_cycle", 64'(cyc), 64'(exp_q[0].cyc));
        void'(exp_q.pop_front());
      end
      ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      if (frame_done) fd_cnt++;
      if (valid_out) out_cnt++;
      if (valid_out || ev) begin
        check("valid_out", {63'b0, valid_out}, {63'b0, ev});
        if (ev) begin
          e = exp_q.pop_front();
          check("pooled_data", {16'b0, dut_out}, 64'(e.data));
          check("frame_done", {63'b0, frame_done}, {63'b0, e.last});
          last_out = e.data;
        end
      end else begin
        check("hold_out", {16'b0, dut_out}, 64'(last_out));
        check("frame_done_idle", {63'b0, frame_done}, 64'd0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      valid_in = 1'b0;
    end
  endtask

  task automatic beat(input int v[6]);
    exp_t e;
    int   m;
    @(posedge clk);
    #1;
    valid_in = 1'b1;
    for (int ch = 0; ch < 6; ch++) begin
      in_ch[ch]    = v[ch];
      fq[ch][r][c] = quant(v[ch]);
    end
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      e.cyc  = cyc + 1;
      e.data = 0;
      e.last = (r == W - 1) && (c == W - 1);
      for (int ch = 0; ch < 6; ch++) begin
        m = fq[ch][r][c];
        if (fq[ch][r][c-1] > m) m = fq[ch][r][c-1];
        if (fq[ch][r-1][c] > m) m = fq[ch][r-1][c];
        if (fq[ch][r-1][c-1] > m) m = fq[ch][r-1][c-1];
        e.data = e.data | (longint'(m) << (8 * ch));
      end
      exp_q.push_back(e);
    end
    c++;
    if (c == W) begin
      c = 0;
      r++;
      if (r == W) r = 0;
    end
  endtask

  function automatic int rnd_val();
    return int'($urandom) >>> $urandom_range(8, 24);
  endfunction

  task automatic run_frame(input int mode, input int nbeats, input bit gaps);
    int v[6];
    out_cnt = 0;
    fd_cnt  = 0;
    for (int b = 0; b < nbeats; b++) begin
      for (int ch = 0; ch < 6; ch++) begin
        case (mode)
          0:       v[ch] = 1000;
          1:       v[ch] = -5000;
          2:       v[ch] = (ch == 0) ? (1 << 20) : (ch == 1) ? 255 : rnd_val();
          3:       v[ch] = (ch == 0) ? 256 * (r * W + c) : rnd_val();
          default: v[ch] = rnd_val();
        endcase
      end
      if (gaps) idle($urandom_range(0, 3));
      beat(v);
    end
  endtask

  task automatic end_frame(input string tag, input int exp_cnt, input int exp_fd);
    idle(3);
    check({tag, "_outputs"}, 64'(out_cnt), 64'(exp_cnt));
    check({tag, "_frame_dones"}, 64'(fd_cnt), 64'(exp_fd));
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b1;
    valid_in = 1'b0;
    for (int ch = 0; ch < 6; ch++) in_ch[ch] = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_frame(0, W * W, 1'b0);
    end_frame("const_1000", 144, 1);
    run_frame(1, W * W, 1'b0);
    end_frame("const_neg", 144, 1);
    run_frame(2, W * W, 1'b0);
    end_frame("saturate", 144, 1);
    run_frame(3, W * W, 1'b0);
    end_frame("ramp", 144, 1);
    run_frame(3, W * W, 1'b1);
    end_frame("ramp_gaps", 144, 1);
    run_frame(4, 2 * W * W, 1'b0);
    end_frame("random_b2b", 288, 2);
    run_frame(4, W * W, 1'b1);
    end_frame("random_gaps", 144, 1);

    run_frame(0, 300, 1'b0);
    idle(2);
    check("partial_outputs", 64'(out_cnt), 64'd72);
    @(posedge clk);
    #1 rst_n = 1'b0;
    idle(3);
    exp_q.delete();
    r = 0;
    c = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame(0, W * W, 1'b0);
    end_frame("after_reset", 144, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/relu_pool1.md
RELU_POOL1 -- requirements
Module: relu_pool1

Interface
REQ-001 Parameter IMG_WIDTH, default 24, conv1 output feature-map width and height in pixels.
REQ-002 Parameter IN_WIDTH, default 32, signed conv1 accumulator width per channel.
REQ-003 Parameter OUT_WIDTH, default 8, signed requantized output width per channel.
REQ-004 Parameter SHIFT, default 8, arithmetic right-shift amount for requantization.
REQ-005 Port clk, input, 1, the single clock.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port valid_in, input, 1, qualifies the in_ch0..in_ch5 beat (driven by conv1 result_valid).
REQ-008 Ports in_ch0..in_ch5, input, IN_WIDTH signed each, conv1 results for one output position.
REQ-009 Ports out_ch0..out_ch5, output, OUT_WIDTH signed each, pooled activations.
REQ-010 Port valid_out, output, 1, qualifies out_ch0..out_ch5 for one cycle.
REQ-011 Port frame_done, output, 1, one-cycle pulse coincident with the last pooled output of a frame.

Function
REQ-012 Each valid beat SHALL be processed per channel as: ReLU (negative -> 0), then arithmetic shift right by SHIFT, then saturate to [0, 2^(OUT_WIDTH-1)-1].
REQ-013 Input SHALL be accepted as exactly IMG_WIDTH*IMG_WIDTH valid beats per frame in row-major order; valid_in gaps of any length SHALL be tolerated without state change.
REQ-014 Column counter (0..IMG_WIDTH-1) and row counter (0..IMG_WIDTH-1) SHALL advance only on valid beats; column wraps to 0 and increments row; row wraps to 0 after the last column of the last row.
REQ-015 Even column beat: quantized values SHALL be held in a per-channel horizontal register.
REQ-016 Odd column, even row: max(horizontal register, current) SHALL be written to a per-channel line buffer of IMG_WIDTH/2 entries at index col>>1.
REQ-017 Odd column, odd row: max(horizontal register, current, line buffer[col>>1]) SHALL be registered onto out_chN with valid_out high on the next clock edge (latency 1 cycle from the completing beat).
REQ-018 valid_out SHALL be low in every other cycle; out_chN SHALL hold its last value when valid_out is low.
REQ-019 Exactly (IMG_WIDTH/2)^2 = 144 outputs per frame SHALL be produced, in row-major pooled order.
REQ-020 frame_done SHALL assert with the output produced by beat (row IMG_WIDTH-1, col IMG_WIDTH-1) and be low otherwise.
REQ-021 Back-to-back frames SHALL be supported with no idle cycle between the last beat of one frame and the first of the next.
REQ-022 No backpressure exists; the block SHALL accept a valid beat every cycle.
REQ-023 IMG_WIDTH SHALL be even; odd values are unsupported.

Reset
REQ-024 On rst_n low, counters, horizontal registers, out_ch0..5, valid_out and frame_done SHALL clear to 0 asynchronously.
REQ-025 Line buffer contents need not be reset; reset mid-frame SHALL discard the partial frame, and the next valid beat SHALL be treated as row 0, column 0.

Structure
REQ-026 Default widths, IMG_WIDTH and SHIFT for layer 1 SHALL live in the shared network-parameter package/include used by the conv stages.
REQ-027 Per-channel ReLU/shift/saturate SHALL be a sub-module relu_requant, instantiated six times.
REQ-028 Line buffer SHALL be inferred as a small register array (12 x 6 x OUT_WIDTH at defaults).

Verification
REQ-029 All channels constant 1000 for 576 beats -> 144 outputs, each 3 (1000>>>8), frame_done on output 144 only.
REQ-030 All channels constant -5000 -> 144 outputs, each 0.
REQ-031 ch0 = 1<<20, ch1 = 255 -> ch0 outputs 127 (saturated), ch1 outputs 0.
REQ-032 ch0 = 256*(row*24+col) ramp -> pooled output (i,j) = min(127, (2i+1)*24+2j+1); the maximum is always the bottom-right pixel.
REQ-033 Random valid_in gaps (0-3 idle cycles) with ramp stimulus -> identical output sequence to gapless run; valid_out exactly 1 cycle after each completing beat.
REQ-034 rst_n pulsed low after 300 beats, then a full frame of 1000 -> no outputs during reset, 144 outputs of 3 afterwards, single frame_done.
